// File: rtl/lcd_ahb_pkg.sv
// Shared encodings for the LCD DMA AHB memory responder.
package lcd_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } slave_state_e;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb_mem_ram.sv
// Word-wide memory: one write port, one registered read port.
// Read and write to the same word on one edge returns the old contents;
// the slave forwards the new data itself in that case.
module ahb_mem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Array write and registered read; contents are deliberately never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB memory responder for the LCD controller DMA master.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | HREADY=1, OKAY; completes a pending good data phase
//   ST_WAIT | HREADY=0, OKAY; counting down inserted wait states
//   ST_ERR1 | HREADY=0, ERROR; first cycle of the two-cycle error
//   ST_ERR2 | HREADY=1, ERROR; second error cycle, may accept next transfer
//
// The RAM read is launched at address-phase acceptance so the word is
// available in the first possible data-phase cycle; the RAM output register
// holds it through any wait states because no new read is issued then.
module ahb_mem_slave
  import lcd_ahb_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  WS_LOAD = 3'(WAIT_STATES);

  slave_state_e  state_q, state_d;
  logic [2:0]    wait_cnt_q, wait_cnt_d;
  logic          dp_valid_q, dp_valid_d;
  logic          dp_write_q, dp_write_d;
  logic [AW-1:0] dp_idx_q, dp_idx_d;
  logic          fwd_q, fwd_d;
  logic [31:0]   fwd_data_q, fwd_data_d;

  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          addr_err;
  logic          accept;
  logic          wr_commit;
  logic          ram_we;
  logic          ram_re;
  logic [31:0]   ram_rdata;
  logic          unused_hburst;

  // Burst type carries no behaviour here; the master's sequencing is trusted.
  assign unused_hburst = ^HBURST;

  // Address decode; a wrapped subtraction below BASE_ADDR lands out of range.
  assign offset   = HADDR - BASE_ADDR;
  assign idx      = offset[AW+1:2];
  assign addr_err = (HSIZE != HSIZE_WORD) || (HADDR[1:0] != 2'b00) || (offset >= SPAN);
  assign accept   = HSEL & HTRANS[1] & HREADY;

  // A write lands on the edge that closes its data phase, never during reset.
  assign wr_commit = dp_valid_q & dp_write_q & HREADY;
  assign ram_we    = wr_commit & HRESET;
  assign ram_re    = accept & ~addr_err & ~HWRITE;

  // Bus response decoded purely from state so HREADY has no input path.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    unique case (state_q)
      ST_WAIT: HREADY = 1'b0;
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 3'd0;
        if (accept) begin
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WS_LOAD;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 3'd1;
        if (wait_cnt_q == 3'd1) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // Data-phase capture; address-phase inputs only matter while HREADY=1.
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    if (HREADY) begin
      dp_valid_d = accept & ~addr_err;
      dp_write_d = HWRITE;
      dp_idx_d   = idx;
      fwd_d      = accept & ~addr_err & ~HWRITE & wr_commit & (dp_idx_q == idx);
      fwd_data_d = HWDATA;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 3'd0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Read data only in the completing cycle of a good read data phase.
  always_comb begin
    HRDATA = 32'h0;
    if (dp_valid_q && !dp_write_q && HREADY) begin
      HRDATA = fwd_q ? fwd_data_q : ram_rdata;
    end
  end

  ahb_mem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk_i   (HCLK),
    .we_i    (ram_we),
    .waddr_i (dp_idx_q),
    .wdata_i (HWDATA),
    .re_i    (ram_re),
    .raddr_i (idx),
    .rdata_o (ram_rdata)
  );

endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words of internal memory; power of two, 16..4096.
REQ-002 Parameter WAIT_STATES, default 0: HREADY-low cycles inserted before each OKAY data phase completes; range 0..7.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
REQ-004 HCLK  input  1  bus clock; all state changes on its rising edge.
REQ-005 HRESET  input  1  reset, synchronous, active-low.
REQ-006 HSEL  input  1  slave select.
REQ-007 HADDR  input  32  byte address, address phase.
REQ-008 HWRITE  input  1  1 = write, 0 = read.
REQ-009 HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-010 HSIZE  input  3  transfer size; only 3'b010 (word) supported.
REQ-011 HBURST  input  3  burst type; informational, no burst-length checking.
REQ-012 HWDATA  input  32  write data, data phase.
REQ-013 HREADY  output  1  transfer-done / bus-ready.
REQ-014 HRESP  output  2  OKAY=00, ERROR=01; RETRY/SPLIT never driven.
REQ-015 HRDATA  output  32  read data, valid when HREADY=1 and HRESP=OKAY in a read data phase.

Function
REQ-016 The block SHALL be the AHB responder serving the LCD controller DMA master: pipelined address/data phases, one outstanding transfer.
REQ-017 A transfer SHALL be accepted on a rising edge when HSEL=1, HTRANS[1]=1 and HREADY=1; HADDR, HWRITE and HSIZE are then registered into data-phase state.
REQ-018 IDLE or BUSY transfers, or HSEL=0, SHALL yield a zero-wait OKAY data phase with no memory access.
REQ-019 An accepted transfer SHALL be an error when HSIZE!=3'b010, HADDR[1:0]!=0, or HADDR lies outside BASE_ADDR..BASE_ADDR+DEPTH_WORDS*4-1; the error is flagged at acceptance.
REQ-020 FSM states: ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2.
REQ-021 ST_IDLE: HREADY=1, HRESP=OKAY. An accepted good transfer goes to ST_WAIT if WAIT_STATES>0, otherwise completes in the next cycle and stays in ST_IDLE. An accepted error transfer goes to ST_ERR1.
REQ-022 ST_WAIT: HREADY=0, HRESP=OKAY, a wait counter loaded with WAIT_STATES and decremented each cycle; at count 1 the FSM returns to ST_IDLE, where the data phase completes with HREADY=1.
REQ-023 ST_ERR1: HREADY=0, HRESP=ERROR, lasting one cycle, then ST_ERR2.
REQ-024 ST_ERR2: HREADY=1, HRESP=ERROR, lasting one cycle; a transfer presented in this cycle is accepted per REQ-017. An errored transfer SHALL NOT write memory.
REQ-025 Write: HWDATA SHALL be captured in the data-phase cycle where HREADY=1, and word (HADDR-BASE_ADDR)>>2 updated on that edge.
REQ-026 Read: HRDATA SHALL present the addressed word in the data-phase cycle where HREADY=1; HRDATA is 32'h0 otherwise.
REQ-027 Read-after-write hazard: when a read data phase targets the word written by the immediately preceding write data phase, HRDATA SHALL return that HWDATA (forwarding).
REQ-028 Back-to-back NONSEQ/SEQ transfers SHALL sustain one word per (WAIT_STATES+1) cycles.
REQ-029 Address-phase signals SHALL be ignored while HREADY=0.

Reset
REQ-030 While HRESET=0 at a rising HCLK: FSM to ST_IDLE, wait counter=0, data-phase valid=0, HREADY=1, HRESP=OKAY, HRDATA=0.
REQ-031 Reset mid-transfer SHALL abandon the transfer without writing memory; memory contents are not reset.

Structure
REQ-032 HTRANS and HRESP encodings and the FSM state enum SHALL live in shared package lcd_ahb_pkg.
REQ-033 Memory array SHALL be sub-module ahb_mem_ram (1 write port, 1 synchronous read port, DEPTH_WORDS x 32); FSM, decode and forwarding live in ahb_mem_slave.

Verification
REQ-034 WAIT_STATES=0: NONSEQ write 32'hDEAD_BEEF to 0x10, then read 0x10 -> HRDATA=32'hDEAD_BEEF, HREADY never low.
REQ-035 WAIT_STATES=2: INCR4 read from 0x40 -> each beat has exactly 2 HREADY-low cycles, 12 data-phase cycles in total, data equals preloaded words 16..19.
REQ-036 Write 32'h1234_5678 to 0x20 immediately followed by a read of 0x20 -> read returns 32'h1234_5678 (forwarding).
REQ-037 Read with HSIZE=3'b001 at 0x8 -> HREADY=0/HRESP=01, then HREADY=1/HRESP=01, then OKAY; memory unchanged.
REQ-038 Write to BASE_ADDR+DEPTH_WORDS*4 -> two-cycle ERROR, no memory write; a following SEQ read of 0x0 -> OKAY with correct data.
REQ-039 HRESET=0 asserted during ST_WAIT of a write -> next cycle HREADY=1, HRESP=00, target word retains its old value.
